// File: rtl/cpu_trace_collector.sv
// Consumer end of the CPU record handshake. Each published record is captured once
// into a FIFO, and the FIFO is drained through a first-word-fall-through read port.
module cpu_trace_collector #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_out,
  input  logic [7:0]    pc_out,
  input  logic [7:0]    opcode,
  input  logic [7:0]    operand_A_out,
  input  logic [7:0]    operand_B_out,
  input  logic [7:0]    result_out_cpu,
  input  logic          carry_out_cpu,
  input  logic          borrow_out_cpu,
  output logic          next_out,
  input  logic          rd_en,
  output logic [41:0]   rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic [15:0]   record_total
);

  localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_t;

  state_t        r_state;
  logic          r_next_out;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_total;
  logic [41:0]   r_mem [DEPTH];

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [41:0]   w_rec;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // Full is judged on the stored count before this edge's pop, so a held record
  // is captured on the edge after the pop that frees a slot.
  assign w_push = (r_state == ST_IDLE) && data_out && !w_full;
  assign w_pop  = rd_en && !w_empty;

  assign w_rec = {pc_out, opcode, operand_A_out, operand_B_out,
                  result_out_cpu, carry_out_cpu, borrow_out_cpu};

  // Acknowledge FSM: one capture per handshake, release once data_out drops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_next_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_out && !w_full) begin
            r_next_out <= 1'b1;
            r_state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!data_out) begin
            r_next_out <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_next_out <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_total <= '0;
    end else begin
      if (w_push) begin
        r_wptr  <= r_wptr + 1'b1;
        r_total <= r_total + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only observable once the count
  // covers them, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  assign rd_data      = r_mem[r_rptr];
  assign next_out     = r_next_out;
  assign empty        = w_empty;
  assign full         = w_full;
  assign count        = r_count;
  assign record_total = r_total;

endmodule

// File: tb/tb_cpu_trace_collector.sv
// Self-checking bench for cpu_trace_collector: a CPU-side handshake driver, a
// host-side reader and a queue model of the record FIFO.
module tb_cpu_trace_collector;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_out = 1'b0;
  logic [7:0]  pc_out = '0;
  logic [7:0]  opcode = '0;
  logic [7:0]  operand_A_out = '0;
  logic [7:0]  operand_B_out = '0;
  logic [7:0]  result_out_cpu = '0;
  logic        carry_out_cpu = 1'b0;
  logic        borrow_out_cpu = 1'b0;
  logic        rd_en = 1'b0;
  logic        next_out;
  logic [41:0] rd_data;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic [15:0] record_total;

  int          errors = 0;
  int          checks = 0;
  logic [41:0] q[$];
  int          total = 0;

  cpu_trace_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_out       (data_out),
    .pc_out         (pc_out),
    .opcode         (opcode),
    .operand_A_out  (operand_A_out),
    .operand_B_out  (operand_B_out),
    .result_out_cpu (result_out_cpu),
    .carry_out_cpu  (carry_out_cpu),
    .borrow_out_cpu (borrow_out_cpu),
    .next_out       (next_out),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .record_total   (record_total)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] pack(input logic [7:0] pc, input logic [7:0] op,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] res, input logic c,
                                       input logic bw);
    return {pc, op, a, b, res, c, bw};
  endfunction

  function automatic logic [41:0] rand_rec();
    return pack(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  task automatic drive_rec(input logic [41:0] r);
    pc_out         = r[41:34];
    opcode         = r[33:26];
    operand_A_out  = r[25:18];
    operand_B_out  = r[17:10];
    result_out_cpu = r[9:2];
    carry_out_cpu  = r[1];
    borrow_out_cpu = r[0];
  endtask

  // Called 1 time unit after the capture edge. The CPU drops data_out after
  // the edge where it sees next_out high, and the acknowledge must last 2 cycles.
  task automatic finish_hs(input string tag);
    int hi;
    hi = 1;
    drive_rec(rand_rec());
    tick();
    data_out = 1'b0;
    while (next_out && hi < 10) begin
      hi++;
      tick();
    end
    check({tag, " ack_len"}, 64'(hi), 64'd2);
  endtask

  task automatic publish(input logic [41:0] r, input string tag);
    int n;
    n = 0;
    drive_rec(r);
    data_out = 1'b1;
    tick();
    while (!next_out && n < 20) begin
      n++;
      tick();
    end
    check({tag, " ack_rise"}, 64'(next_out), 64'd1);
    if (!next_out) begin
      data_out = 1'b0;
      return;
    end
    q.push_back(r);
    total++;
    finish_hs(tag);
    check({tag, " count"}, 64'(count), 64'(q.size()));
  endtask

  task automatic pop(input string tag);
    check({tag, " empty"}, 64'(empty), 64'd0);
    if (q.size() > 0) check({tag, " data"}, 64'(rd_data), 64'(q[0]));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check({tag, " count"}, 64'(count), 64'(q.size()));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    data_out = 1'b0;
    rd_en = 1'b0;
    #3;
    q.delete();
    total = 0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    logic [41:0] r;
    logic [41:0] exp1;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst next_out", 64'(next_out), 64'd0);
    check("rst count", 64'(count), 64'd0);
    check("rst empty", 64'(empty), 64'd1);
    check("rst full", 64'(full), 64'd0);
    check("rst total", 64'(record_total), 64'd0);
    rst = 1'b1;
    tick();

    // Single record
    exp1 = {8'h05, 8'h80, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0};
    publish(pack(8'h05, 8'h80, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0), "single");
    check("single rd_data", 64'(rd_data), 64'(exp1));
    check("single total", 64'(record_total), 64'd1);
    pop("single pop");
    check("single empty_after", 64'(empty), 64'd1);

    // Back-to-back, no reads
    for (int i = 0; i < 5; i++) publish(rand_rec(), "b2b");
    check("b2b count", 64'(count), 64'd5);
    check("b2b total", 64'(record_total), 64'(total));
    for (int i = 0; i < 5; i++) pop("b2b pop");

    // Full backpressure
    for (int i = 0; i < DEPTH; i++) publish(rand_rec(), "fill");
    check("fill full", 64'(full), 64'd1);
    check("fill count", 64'(count), 64'(DEPTH));
    r = rand_rec();
    drive_rec(r);
    data_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp next_out", 64'(next_out), 64'd0);
      check("bp count", 64'(count), 64'(DEPTH));
    end
    check("bp head", 64'(rd_data), 64'(q[0]));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(q.pop_front());
    check("bp pop count", 64'(count), 64'(DEPTH - 1));
    check("bp pop next_out", 64'(next_out), 64'd0);
    tick();
    check("bp capture next_out", 64'(next_out), 64'd1);
    check("bp capture count", 64'(count), 64'(DEPTH));
    q.push_back(r);
    total++;
    finish_hs("bp");
    check("bp total", 64'(record_total), 64'(total));
    while (q.size() > 3) pop("bp drain");

    // Simultaneous push and pop at count 3
    r = rand_rec();
    drive_rec(r);
    data_out = 1'b1;
    rd_en = 1'b1;
    check("pp oldest", 64'(rd_data), 64'(q[0]));
    tick();
    rd_en = 1'b0;
    void'(q.pop_front());
    q.push_back(r);
    total++;
    check("pp next_out", 64'(next_out), 64'd1);
    check("pp count", 64'(count), 64'd3);
    finish_hs("pp");
    while (q.size() > 0) pop("pp drain");

    // Async reset while in ACK, then rd_en on the empty FIFO
    publish(rand_rec(), "pre_rst");
    publish(rand_rec(), "pre_rst");
    r = rand_rec();
    drive_rec(r);
    data_out = 1'b1;
    tick();
    check("ack before rst", 64'(next_out), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst next_out", 64'(next_out), 64'd0);
    check("arst count", 64'(count), 64'd0);
    check("arst empty", 64'(empty), 64'd1);
    check("arst total", 64'(record_total), 64'd0);
    q.delete();
    total = 0;
    data_out = 1'b0;
    rd_en = 1'b1;
    #1;
    rst = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    check("empty rd count", 64'(count), 64'd0);
    check("empty rd empty", 64'(empty), 64'd1);
    check("empty rd full", 64'(full), 64'd0);
    check("empty rd total", 64'(record_total), 64'd0);
    publish(r, "represent");
    check("represent total", 64'(record_total), 64'd1);
    pop("represent pop");

    // Pointer wrap with interleaved reads, from a fresh reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      publish(rand_rec(), "wrap");
      if (q.size() >= 5 || $urandom_range(0, 1) == 1) pop("wrap pop");
    end
    check("wrap total", 64'(record_total), 64'd20);
    while (q.size() > 0) pop("wrap drain");
    check("wrap empty", 64'(empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
